// File: rtl/shreg_pkg.sv
// Shared types for shared_reg_arbiter: FSM state encoding and operation codes.
package shreg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

endpackage

// File: rtl/reg_bank_sync_clr.sv
// WIDTH-bit D flip-flop bank with load enable and synchronous clear to CLR_VAL.
// Clear takes priority over load; asynchronous active-low reset also restores CLR_VAL.
module reg_bank_sync_clr
    import shreg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= CLR_VAL;
        end else if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer owning one shared WIDTH-bit register among N requesters.
// Optional ARB_LOCK_EN adds a lock port that lets the served requester chain operations.
module shared_reg_arbiter
    import shreg_pkg::*;
#(
    parameter int               N       = 4,
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       op,
    input  logic [N*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]       lock,
`endif
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_win, w_win_nxt;
    logic [PW-1:0]    w_pick;
    logic             w_any;
    logic [N-1:0]     r_gnt, w_gnt_nxt;
    logic [N-1:0]     r_ack, w_ack_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_wr_en, w_wr_clr;
    logic             w_req_win, w_op_win, w_lock_win;
    logic [WIDTH-1:0] w_wdata_win;

    // First requester at or above the pointer, wrapping N-1 -> 0.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        w_pick = '0;
        w_any  = 1'b0;
        for (int unsigned k = 0; k < int'(N); k++) begin
            idx = (int'(r_ptr) + k) % int'(N);
            if (!w_any && req[idx]) begin
                w_any  = 1'b1;
                w_pick = PW'(idx);
            end
        end
    end

    assign w_req_win   = req[r_win];
    assign w_op_win    = op[r_win];
    assign w_wdata_win = wdata[r_win*WIDTH +: WIDTH];

`ifdef ARB_LOCK_EN
    assign w_lock_win = lock[r_win];
`else
    assign w_lock_win = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_wr_en     = 1'b0;
        w_wr_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt       = GRANT;
                    w_win_nxt         = w_pick;
                    w_gnt_nxt[w_pick] = 1'b1;
                end
            end
            GRANT: begin
                if (w_req_win) begin
                    w_wr_en          = (w_op_win == OP_LOAD);
                    w_wr_clr         = (w_op_win == OP_CLEAR);
                    w_ack_nxt[r_win] = 1'b1;
                    w_ptr_nxt        = (r_win == PW'(N - 1)) ? '0 : r_win + 1'b1;
                    w_state_nxt      = ACK;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACK: begin
                if (w_lock_win && w_req_win) begin
                    w_state_nxt      = GRANT;
                    w_gnt_nxt[r_win] = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    reg_bank_sync_clr #(
        .WIDTH   (WIDTH),
        .CLR_VAL (CLR_VAL)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_wr_en),
        .i_clr (w_wr_clr),
        .i_d   (w_wdata_win),
        .o_q   (q)
    );

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign busy = r_busy;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table, corner sequences, random vs model.
// Lock sequence is exercised when ARB_LOCK_EN is defined.
module tb_shared_reg_arbiter;

    localparam int             N   = 4;
    localparam int             W   = 8;
    localparam logic [W-1:0]   CLR = 8'h00;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   op;
    logic [N*W-1:0] wdata;
`ifdef ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which stage (0 idle, 1 granted, 2 acked) and who is being served.
    int           m_stage;
    int           m_who;
    int           m_ptr;
    logic [W-1:0] m_q;

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   op;
        logic [N*W-1:0] wd;
        logic [N-1:0]   eg;
        logic [N-1:0]   ea;
        logic [W-1:0]   eq;
        logic           eb;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    shared_reg_arbiter #(
        .N       (N),
        .WIDTH   (W),
        .CLR_VAL (CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .op    (op),
        .wdata (wdata),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    function automatic logic [N*W-1:0] pk(input logic [7:0] d3, input logic [7:0] d2,
                                          input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [N-1:0] m_gnt();
        return (m_stage == 1) ? (N'(1) << m_who) : '0;
    endfunction

    function automatic logic [N-1:0] m_ack();
        return (m_stage == 2) ? (N'(1) << m_who) : '0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ea,
                           input logic [W-1:0] eq, input logic eb);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".ack"}, 32'(ack), 32'(ea));
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic model_clear();
        m_stage = 0;
        m_who   = 0;
        m_ptr   = 0;
        m_q     = CLR;
    endtask

    task automatic model_step();
        case (m_stage)
            0: begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N]) begin
                        m_who   = (m_ptr + k) % N;
                        m_stage = 1;
                    end
                end
            end
            1: begin
                if (req[m_who]) begin
                    m_q     = op[m_who] ? CLR : wdata[m_who*W +: W];
                    m_ptr   = (m_who + 1) % N;
                    m_stage = 2;
                end else begin
                    m_stage = 0;
                end
            end
            default: begin
                m_stage = 0;
`ifdef ARB_LOCK_EN
                if (lock[m_who] && req[m_who]) m_stage = 1;
`endif
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        wdata = '0;
`ifdef ARB_LOCK_EN
        lock  = '0;
`endif
        #1;
        chk_all("reset", '0, '0, CLR, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [7:0]   fd[4];
        logic [7:0]   prev_q;
        logic [N-1:0] sg;
        logic [N-1:0] sa;

        rst_n = 1'b1;
        req   = '0;
        op    = '0;
        wdata = '0;
`ifdef ARB_LOCK_EN
        lock  = '0;
`endif
        model_clear();

        // Async reset in the middle of a pending load.
        do_reset();
        req   = 4'b0010;
        wdata = pk(8'h00, 8'h00, 8'h5A, 8'h00);
        step();
        step();
        chk("rst.preload.q", 32'(q), 32'h5A);
        req = '0;
        step();
        req   = 4'b0001;
        wdata = pk(8'h00, 8'h00, 8'h00, 8'hA5);
        step();
        chk("rst.pending.gnt", 32'(gnt), 32'b0001);
        #1 rst_n = 1'b0;
        #1 chk_all("rst.async", '0, '0, CLR, 1'b0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (3) step();
        chk_all("rst.nowrite", '0, '0, CLR, 1'b0);

        // All four holding requests: strict pointer order, 3 cycles per operation.
        do_reset();
        fd     = '{8'h11, 8'h22, 8'h33, 8'h44};
        req    = '1;
        op     = '0;
        wdata  = pk(fd[3], fd[2], fd[1], fd[0]);
        prev_q = CLR;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all($sformatf("fair%0d.g", k), N'(1) << (k % N), '0, prev_q, 1'b1);
            step();
            chk_all($sformatf("fair%0d.a", k), '0, N'(1) << (k % N), fd[k % N], 1'b1);
            prev_q = fd[k % N];
            step();
            chk_all($sformatf("fair%0d.i", k), '0, '0, prev_q, 1'b0);
        end

        // Vector table: single load, clear, abort with pointer kept, follow-up grants.
        do_reset();
        tbl[0]  = '{4'b0100, 4'b0000, pk(8'h00, 8'h3C, 8'h00, 8'h00), 4'b0100, 4'b0000, 8'h00, 1'b1};
        tbl[1]  = '{4'b0100, 4'b0000, pk(8'h00, 8'h3C, 8'h00, 8'h00), 4'b0000, 4'b0100, 8'h3C, 1'b1};
        tbl[2]  = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 4'b0000, 8'h3C, 1'b0};
        tbl[3]  = '{4'b0010, 4'b0010, pk(8'h00, 8'h00, 8'hEE, 8'h00), 4'b0010, 4'b0000, 8'h3C, 1'b1};
        tbl[4]  = '{4'b0010, 4'b0010, pk(8'h00, 8'h00, 8'hEE, 8'h00), 4'b0000, 4'b0010, 8'h00, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 4'b0000, 8'h00, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h55), 4'b0001, 4'b0000, 8'h00, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h55), 4'b0000, 4'b0000, 8'h00, 1'b0};
        tbl[8]  = '{4'b0011, 4'b0000, pk(8'h00, 8'h00, 8'h66, 8'h55), 4'b0001, 4'b0000, 8'h00, 1'b1};
        tbl[9]  = '{4'b0011, 4'b0000, pk(8'h00, 8'h00, 8'h66, 8'h55), 4'b0000, 4'b0001, 8'h55, 1'b1};
        tbl[10] = '{4'b0010, 4'b0000, pk(8'h00, 8'h00, 8'h66, 8'h55), 4'b0000, 4'b0000, 8'h55, 1'b0};
        tbl[11] = '{4'b0010, 4'b0000, pk(8'h00, 8'h00, 8'h66, 8'h55), 4'b0010, 4'b0000, 8'h55, 1'b1};
        tbl[12] = '{4'b0010, 4'b0000, pk(8'h00, 8'h00, 8'h66, 8'h55), 4'b0000, 4'b0010, 8'h66, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, pk(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 4'b0000, 8'h66, 1'b0};
        for (int v = 0; v < 14; v++) begin
            req   = tbl[v].req;
            op    = tbl[v].op;
            wdata = tbl[v].wd;
            step();
            chk_all($sformatf("vec%0d", v), tbl[v].eg, tbl[v].ea, tbl[v].eq, tbl[v].eb);
        end

`ifdef ARB_LOCK_EN
        // Locked requester chains operations every 2 cycles and starves requester 0.
        do_reset();
        lock  = 4'b1000;
        req   = 4'b1000;
        op    = '0;
        wdata = pk(8'h01, 8'h00, 8'h00, 8'h00);
        step();
        chk_all("lock.g1", 4'b1000, '0, 8'h00, 1'b1);
        step();
        chk_all("lock.a1", '0, 4'b1000, 8'h01, 1'b1);
        req   = 4'b1001;
        wdata = pk(8'h02, 8'h00, 8'h00, 8'h77);
        step();
        chk_all("lock.g2", 4'b1000, '0, 8'h01, 1'b1);
        step();
        chk_all("lock.a2", '0, 4'b1000, 8'h02, 1'b1);
        wdata = pk(8'h03, 8'h00, 8'h00, 8'h77);
        step();
        chk_all("lock.g3", 4'b1000, '0, 8'h02, 1'b1);
        step();
        chk_all("lock.a3", '0, 4'b1000, 8'h03, 1'b1);
        lock = '0;
        step();
        chk_all("lock.idle", '0, '0, 8'h03, 1'b0);
        step();
        chk_all("lock.r0g", 4'b0001, '0, 8'h03, 1'b1);
        step();
        chk_all("lock.r0a", '0, 4'b0001, 8'h77, 1'b1);
        req = '0;
        step();
`endif

        // Random protocol-following requesters against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            sg = m_gnt();
            sa = m_ack();
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(3) == 0) begin
                        req[i]          = 1'b1;
                        op[i]           = ($urandom_range(4) == 0);
                        wdata[i*W +: W] = W'($urandom);
                    end
                end else if (sa[i]) begin
                    req[i] = 1'b0;
                end else if (sg[i] && ($urandom_range(7) == 0)) begin
                    req[i] = 1'b0;
                end
            end
            step();
            chk_all("rand", m_gnt(), m_ack(), m_q, (m_stage != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Round-robin arbiter and sequencer that shares one WIDTH-bit storage register (a bank of D flip-flops with synchronous clear) among N requesters.
- Each requester asks for a load of its own data or a clear of the register; the block grants one requester at a time, applies the operation and acknowledges it.
- It is the owner/controller of the shared register in any datapath where several agents write a common state word.

## Interface
- N, 4: number of requesters (2..8)
- WIDTH, 8: register width in bits
- CLR_VAL, 0: value written by a clear operation (WIDTH bits)
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- req  in  N  per-requester request level
- op  in  N  per-requester operation: 0 = load, 1 = clear
- wdata  in  N*WIDTH  per-requester load data, requester i at bits [i*WIDTH +: WIDTH]
- lock  in  N  per-requester ownership hold (present only when ARB_LOCK_EN defined)
- gnt  out  N  one-hot grant, at most one bit set
- ack  out  N  one-cycle completion pulse to the served requester
- q  out  WIDTH  shared register contents
- busy  out  1  high in GRANT and ACK states

## Operation
- Reset (rst_n low, immediate): state IDLE, q = CLR_VAL, gnt = 0, ack = 0, busy = 0, round-robin pointer = 0.
- States: IDLE, GRANT, ACK.
- IDLE: if any req bit set, winner = first set bit searching from pointer upward, wrapping N-1 -> 0; go to GRANT with gnt[winner] = 1. No req: stay IDLE.
- GRANT: requester keeps req high; op[winner]/wdata[winner] sampled this cycle; on the clock edge q <= wdata (load) or CLR_VAL (clear); go to ACK; pointer <= (winner+1) mod N.
- GRANT with req[winner] dropped: abort; no write, no ack, pointer unchanged, back to IDLE.
- ACK: gnt cleared, ack[winner] = 1 for exactly one cycle, busy high; go to IDLE. No arbitration in ACK.
- Requester must drop req in the cycle after ack or it re-enters arbitration as a new request.
- Requests from non-granted requesters are ignored while busy; they are neither lost nor queued beyond their held req level.
- All N requesting simultaneously: served in pointer order, every requester served within N operations (no starvation).
- rst_n asserted mid-operation: pending write discarded, all outputs return to reset values immediately.

## Timing
- Request seen in IDLE at cycle 0 -> gnt at cycle 1 -> q updated and ack high at cycle 2 -> IDLE at cycle 3.
- Throughput: one operation per 3 cycles; back-to-back requester gets gnt at cycle 4.
- gnt, ack, busy, q are all registered outputs; no combinational input-to-output path.

## Configuration
- ARB_LOCK_EN defined: lock port exists; in ACK, if lock[winner] and req[winner] are high, next state is GRANT for the same requester (skip IDLE, pointer not advanced), giving one operation per 2 cycles; lock dropped -> normal ACK -> IDLE.
- ARB_LOCK_EN undefined: no lock port; behaviour exactly as Operation above.

## Structure
- Package shreg_pkg: state enum (IDLE, GRANT, ACK), OP_LOAD = 1'b0, OP_CLEAR = 1'b1.
- Sub-module reg_bank_sync_clr: WIDTH-bit D-FF bank with enable, synchronous clear to CLR_VAL, async active-low reset; holds q. The arbiter FSM and pointer live in the top.

## Test plan
- Reset: rst_n low mid-GRANT with load 0xA5 pending -> q = 0x00, gnt = 0, ack = 0 immediately; no write after release.
- Single load: req[2] = 1, op = 0, wdata[2] = 0x3C at cycle 0 -> gnt = 4'b0100 at cycle 1, q = 0x3C and ack = 4'b0100 at cycle 2, busy low at cycle 3.
- Clear: q = 0x3C, req[1] with op = 1 -> q = 0x00 two cycles later, ack[1] pulse.
- Fairness: all four req held from reset -> grants in order 0,1,2,3,0, each 3 cycles apart, q tracks each wdata.
- Abort: req[0] dropped during GRANT -> no ack, q unchanged, next grant goes to requester 0 again if re-requested (pointer unchanged).
- ARB_LOCK_EN: req[3] and lock[3] held with wdata 0x01, 0x02, 0x03 -> acks 2 cycles apart, req[0] starved until lock drops, then served next.
